coproc_instruction_issuer: RTL and testbench



---
 rtl/coproc_instruction_issuer.sv | 205 ++++++++++++++++++++
 tb/tb_coproc_instruction_issuer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coproc_instruction_issuer.sv
// coproc_instruction_issuer
// Initiator side of the coprocessor instruction handshake. Queues 32-bit
// instructions from the HPS bridge, issues them one at a time with a single
// cycle strobe, follows the coprocessor wait_signal, and captures READ
// results (opcode 4'b0001) into a result FIFO for the HPS to drain.
// Optional BUSY watchdog: define COPROC_TIMEOUT_EN.
module coproc_instruction_issuer #(
  parameter int CMD_DEPTH      = 8,
  parameter int RES_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] instruction,
  output logic        activate_instruction,
  input  logic        wait_signal,
  input  logic [15:0] output_reg,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] issued_count
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam logic [3:0] OP_READ = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACK,
    S_BUSY,
    S_CAPTURE
  } state_t;

  state_t         r_state;
  logic [31:0]    r_cmdMem [CMD_DEPTH];
  logic [CAW-1:0] r_cmdWrPtr;
  logic [CAW-1:0] r_cmdRdPtr;
  logic [CAW:0]   r_cmdCount;
  logic [15:0]    r_resMem [RES_DEPTH];
  logic [RAW-1:0] r_resWrPtr;
  logic [RAW-1:0] r_resRdPtr;
  logic [RAW:0]   r_resCount;
  logic [15:0]    r_resData;
  logic [31:0]    r_instruction;
  logic           r_activate;
  logic           r_isRead;
  logic           r_ackMiss;
  logic           r_timeoutErr;
  logic [15:0]    r_issuedCount;

`ifdef COPROC_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] r_busyCnt;
`endif

  logic           w_cmdPush;
  logic           w_cmdPop;
  logic           w_cmdFull;
  logic [31:0]    w_cmdHead;
  logic           w_resPush;
  logic           w_resPop;
  logic           w_resHasSlot;
  logic [RAW-1:0] w_resRdNext;
  logic [15:0]    w_resHeadNext;
  logic           w_canIssue;

  // The ISSUE cycle frees the head slot, so a push is accepted even when full
  assign w_cmdPop   = (r_state == S_ISSUE);
  assign w_cmdFull  = (r_cmdCount == (CAW+1)'(CMD_DEPTH));
  assign cmd_ready  = !w_cmdFull || w_cmdPop;
  assign w_cmdPush  = cmd_valid && cmd_ready;
  assign w_cmdHead  = r_cmdMem[r_cmdRdPtr];

  assign res_valid    = (r_resCount != '0);
  assign w_resPush    = (r_state == S_CAPTURE);
  assign w_resPop     = res_valid && res_ready;
  assign w_resHasSlot = (r_resCount != (RAW+1)'(RES_DEPTH)) || w_resPop;
  assign w_resRdNext  = w_resPop ? r_resRdPtr + 1'b1 : r_resRdPtr;
  // A value pushed this cycle is not in memory yet, so forward it when it becomes the head
  assign w_resHeadNext = (w_resPush && (w_resRdNext == r_resWrPtr)) ? output_reg
                                                                     : r_resMem[w_resRdNext];

  // A READ only issues when its result is guaranteed a slot at CAPTURE time
  assign w_canIssue = (r_cmdCount != '0) && !wait_signal &&
                      ((w_cmdHead[3:0] != OP_READ) || w_resHasSlot);

  assign busy                 = (r_state != S_IDLE) || (r_cmdCount != '0);
  assign instruction          = r_instruction;
  assign activate_instruction = r_activate;
  assign res_data             = r_resData;
  assign timeout_err          = r_timeoutErr;
  assign issued_count         = r_issuedCount;

  // Command FIFO storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (w_cmdPush) r_cmdMem[r_cmdWrPtr] <= cmd_data;
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmdWrPtr <= '0;
      r_cmdRdPtr <= '0;
      r_cmdCount <= '0;
    end else begin
      if (w_cmdPush) r_cmdWrPtr <= r_cmdWrPtr + 1'b1;
      if (w_cmdPop)  r_cmdRdPtr <= r_cmdRdPtr + 1'b1;
      if (w_cmdPush && !w_cmdPop)      r_cmdCount <= r_cmdCount + 1'b1;
      else if (!w_cmdPush && w_cmdPop) r_cmdCount <= r_cmdCount - 1'b1;
    end
  end

  // Result FIFO storage, written in the CAPTURE cycle
  always_ff @(posedge clk) begin
    if (w_resPush) r_resMem[r_resWrPtr] <= output_reg;
  end

  // Result FIFO pointers, occupancy and the registered head value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resWrPtr <= '0;
      r_resRdPtr <= '0;
      r_resCount <= '0;
      r_resData  <= '0;
    end else begin
      if (w_resPush) r_resWrPtr <= r_resWrPtr + 1'b1;
      r_resRdPtr <= w_resRdNext;
      if (w_resPush && !w_resPop)      r_resCount <= r_resCount + 1'b1;
      else if (!w_resPush && w_resPop) r_resCount <= r_resCount - 1'b1;
      if (w_resPush || w_resPop) r_resData <= w_resHeadNext;
    end
  end

  // Issue sequencing: IDLE -> ISSUE -> ACK -> BUSY (-> CAPTURE for READs) -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_instruction <= '0;
      r_activate    <= 1'b0;
      r_isRead      <= 1'b0;
      r_ackMiss     <= 1'b0;
      r_timeoutErr  <= 1'b0;
      r_issuedCount <= '0;
`ifdef COPROC_TIMEOUT_EN
      r_busyCnt     <= '0;
`endif
    end else begin
      r_activate <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_canIssue) begin
            r_state       <= S_ISSUE;
            r_instruction <= w_cmdHead;
            r_activate    <= 1'b1;
            r_isRead      <= (w_cmdHead[3:0] == OP_READ);
          end
        end
        S_ISSUE: begin
          r_issuedCount <= r_issuedCount + 16'd1;
          r_ackMiss     <= 1'b0;
          r_state       <= S_ACK;
        end
        S_ACK: begin
          if (wait_signal) begin
            r_state <= S_BUSY;
`ifdef COPROC_TIMEOUT_EN
            r_busyCnt <= '0;
`endif
          end else if (r_ackMiss) begin
            r_timeoutErr <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_ackMiss <= 1'b1;
          end
        end
        S_BUSY: begin
`ifdef COPROC_TIMEOUT_EN
          if (wait_signal) begin
            if (r_busyCnt == TCW'(TIMEOUT_CYCLES - 1)) begin
              r_timeoutErr <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_busyCnt <= r_busyCnt + 1'b1;
            end
          end else begin
            r_state <= r_isRead ? S_CAPTURE : S_IDLE;
          end
`else
          if (!wait_signal) r_state <= r_isRead ? S_CAPTURE : S_IDLE;
`endif
        end
        S_CAPTURE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_instruction_issuer.sv
// tb_coproc_instruction_issuer
// Drives coproc_instruction_issuer with a behavioural coprocessor model and
// scoreboards issued instructions and READ results.
`timescale 1ns/1ps
module tb_coproc_instruction_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] instruction;
  logic        activate_instruction;
  logic        wait_signal;
  logic [15:0] output_reg;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        timeout_err;
  logic [15:0] issued_count;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] expCmd[$];
  logic [15:0] expRes[$];
  int   activeCount   = 0;
  int   acceptedTotal = 0;
  int   holdCycles    = 2;
  int   missLeft      = 0;
  logic forceBusy     = 1'b0;
  logic stuckMode     = 1'b0;
  logic timeoutProbe  = 1'b0;
  logic latencyProbe  = 1'b0;

  always #5 clk = ~clk;

  coproc_instruction_issuer #(
    .CMD_DEPTH(8),
    .RES_DEPTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_data(cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .instruction(instruction),
    .activate_instruction(activate_instruction),
    .wait_signal(wait_signal),
    .output_reg(output_reg),
    .res_data(res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy),
    .timeout_err(timeout_err),
    .issued_count(issued_count)
  );

  // Single comparison point: counts every check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Offer one command for a cycle; remember it only if the DUT accepts it
  task automatic applyStimulus(input logic [31:0] data, output logic accepted);
    cmd_data  = data;
    cmd_valid = 1'b1;
    accepted  = cmd_ready;
    if (accepted) begin
      expCmd.push_back(data);
      acceptedTotal++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Every output must sit at its reset value
  task automatic checkResetValues();
    checkOutput("rstCmdReady", cmd_ready, 1);
    checkOutput("rstInstr", instruction, 0);
    checkOutput("rstActivate", activate_instruction, 0);
    checkOutput("rstResValid", res_valid, 0);
    checkOutput("rstResData", res_data, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstTimeout", timeout_err, 0);
    checkOutput("rstIssued", issued_count, 0);
  endtask

  // Wait until every accepted command has issued and the DUT has gone quiet
  task automatic waitIdle(input int maxCycles, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || expCmd.size() != 0) && n < maxCycles);
    checkOutput(tag, 32'(expCmd.size()) + 32'(busy), 0);
  endtask

  // Pop one result and compare it with the oldest expected value
  task automatic drainResult(input string tag);
    checkOutput({tag, "Valid"}, res_valid, 1);
    if (expRes.size() == 0) checkOutput({tag, "Extra"}, 32'(expRes.size()), 1);
    else checkOutput({tag, "Data"}, res_data, expRes.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expCmd.delete();
    expRes.delete();
    acceptedTotal = 0;
    @(negedge clk);
  endtask

  // Coprocessor model: raises wait one cycle after the strobe, holds it, and
  // presents the READ result as wait falls
  initial begin : coprocModel
    logic [31:0] expIns;
    wait_signal = 1'b0;
    output_reg  = '0;
    forever begin
      @(negedge clk);
      if (activate_instruction) begin
        activeCount++;
        if (expCmd.size() == 0) begin
          checkOutput("spuriousIssue", 32'(expCmd.size()), 1);
          expIns = instruction;
        end else begin
          expIns = expCmd.pop_front();
          checkOutput("issueOrder", instruction, expIns);
        end
        if (missLeft > 0) begin
          missLeft--;
        end else begin
          @(negedge clk);
          checkOutput("strobeWidth", activate_instruction, 0);
          wait_signal = 1'b1;
          if (stuckMode) begin
            if (timeoutProbe) begin
              repeat (16) @(negedge clk);
              checkOutput("toBefore", timeout_err, 0);
              @(negedge clk);
              checkOutput("toFlag", timeout_err, 1);
              checkOutput("toIdle", busy, 0);
            end
            while (stuckMode) @(negedge clk);
            wait_signal = 1'b0;
          end else begin
            repeat (holdCycles) @(negedge clk);
            wait_signal = 1'b0;
            if (expIns[3:0] == 4'b0001) begin
              output_reg = expIns[31:16] ^ 16'hBEEF;
              expRes.push_back(expIns[31:16] ^ 16'hBEEF);
              if (latencyProbe) begin
                @(negedge clk);
                checkOutput("resEarly", res_valid, 0);
                @(negedge clk);
                checkOutput("resLatency", res_valid, 1);
              end
            end
          end
        end
      end else begin
        wait_signal = forceBusy;
      end
    end
  end

  // Main sequence of scenarios
  initial begin : mainSeq
    logic acc;
    int   base;
    reset     = 1'b1;
    cmd_data  = '0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues();
    reset = 1'b0;
    @(negedge clk);

    // Single WRITE
    applyStimulus(32'h0000_1232, acc);
    waitIdle(100, "t1Idle");
    checkOutput("t1Pulses", activeCount, 1);
    checkOutput("t1Issued", issued_count, 16'(acceptedTotal));
    checkOutput("t1NoResult", res_valid, 0);

    // Single READ with result latency
    latencyProbe = 1'b1;
    applyStimulus(32'h0000_0451, acc);
    waitIdle(100, "t2Idle");
    latencyProbe = 1'b0;
    drainResult("t2");
    checkOutput("t2Empty", res_valid, 0);

    // Result back-pressure
    for (int k = 1; k <= 8; k++) applyStimulus({16'(k), 16'h0451}, acc);
    waitIdle(400, "t3Fill");
    base = activeCount;
    applyStimulus(32'h0009_0451, acc);
    repeat (20) @(negedge clk);
    checkOutput("t3Blocked", activeCount, base);
    checkOutput("t3Busy", busy, 1);
    drainResult("t3First");
    waitIdle(100, "t3Resume");
    checkOutput("t3Issued", activeCount, base + 1);
    for (int k = 0; k < 8; k++) drainResult("t3Drain");
    checkOutput("t3Empty", res_valid, 0);

    // Command FIFO full while the coprocessor stays busy
    forceBusy = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) applyStimulus({16'(16'h0100 + k), 16'h0002}, acc);
    checkOutput("t4Full", cmd_ready, 0);
    applyStimulus(32'hDEAD_0003, acc);
    checkOutput("t4Ignored", acc, 0);
    base = activeCount;
    forceBusy = 1'b0;
    waitIdle(300, "t4Idle");
    checkOutput("t4Count", activeCount, base + 8);
    checkOutput("t4Issued", issued_count, 16'(acceptedTotal));
    checkOutput("t4NoError", timeout_err, 0);

    // Protocol miss on the first of two commands
    missLeft = 1;
    base = activeCount;
    applyStimulus(32'h0000_5552, acc);
    applyStimulus(32'h0000_6662, acc);
    waitIdle(100, "t5Idle");
    checkOutput("t5Error", timeout_err, 1);
    checkOutput("t5Count", activeCount, base + 2);
    checkOutput("t5Issued", issued_count, 16'(acceptedTotal));

`ifdef COPROC_TIMEOUT_EN
    // BUSY watchdog with wait_signal stuck high
    applyReset();
    stuckMode    = 1'b1;
    timeoutProbe = 1'b1;
    applyStimulus(32'h0000_A002, acc);
    repeat (30) @(negedge clk);
    checkOutput("t6Error", timeout_err, 1);
    base = activeCount;
    applyStimulus(32'h0000_B002, acc);
    repeat (10) @(negedge clk);
    checkOutput("t6Hold", activeCount, base);
    timeoutProbe = 1'b0;
    stuckMode    = 1'b0;
    waitIdle(100, "t6Idle");
    checkOutput("t6Resume", activeCount, base + 1);
`endif

    // Asynchronous reset in the middle of BUSY
    applyReset();
    stuckMode = 1'b1;
    applyStimulus(32'h0000_7772, acc);
    applyStimulus(32'h0000_8882, acc);
    repeat (8) @(negedge clk);
    checkOutput("t7Busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues();
    stuckMode = 1'b0;
    expCmd.delete();
    expRes.delete();
    acceptedTotal = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(32'h0000_9992, acc);
    waitIdle(100, "t7Idle");
    checkOutput("t7Issued", issued_count, 1);
    checkOutput("t7NoResult", res_valid, 0);

    $display("test done: total=%0d bad=%0d", testCount, failCount);
    $finish;
  end

  initial begin : watchdog
    #100000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", testCount, failCount);
    $finish;
  end

endmodule
